// File: rtl/switch_bounce_emulator.sv
// Bounce waveform generator: on each change of the clean command level it emits a burst of
// glitch toggles, with optional LFSR jitter on the spacing, and then settles at the new level.
module switch_bounce_emulator #(
    parameter int unsigned BOUNCE_INTERVAL = 100000,
    parameter int unsigned BOUNCE_PAIRS    = 7,
    parameter logic [15:0] JITTER_MASK     = 16'h0000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_in,
    input  logic bypass,
    output logic bounce_out,
    output logic busy,
    output logic done
);

    // state  | meaning
    // IDLE   | output settled at target, waiting for a command change
    // BOUNCE | burst in progress, toggling every interval until toggles_left hits 0
    typedef enum logic {IDLE, BOUNCE} state_t;

    localparam logic [31:0] TOGGLES_INIT = 32'(2 * BOUNCE_PAIRS);

    state_t      state, state_nxt;
    logic        target, target_nxt;
    logic        bounce_nxt, busy_nxt, done_nxt;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [31:0] interval_cnt, interval_nxt, interval_i;
    logic [31:0] toggles_left, toggles_nxt;

    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign interval_i = 32'(BOUNCE_INTERVAL) + {16'h0000, lfsr & JITTER_MASK};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target       <= RESET_LEVEL;
            bounce_out   <= RESET_LEVEL;
            busy         <= 1'b0;
            done         <= 1'b0;
            lfsr         <= LFSR_SEED;
            interval_cnt <= '0;
            toggles_left <= '0;
        end else begin
            state        <= state_nxt;
            target       <= target_nxt;
            bounce_out   <= bounce_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            lfsr         <= {lfsr[14:0], lfsr_fb};
            interval_cnt <= interval_nxt;
            toggles_left <= toggles_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        target_nxt   = target;
        bounce_nxt   = bounce_out;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        interval_nxt = interval_cnt;
        toggles_nxt  = toggles_left;

        if (bypass) begin
            state_nxt    = IDLE;
            busy_nxt     = 1'b0;
            interval_nxt = '0;
            toggles_nxt  = '0;
            bounce_nxt   = cmd_in;
            target_nxt   = cmd_in;
        end else if (cmd_in != target) begin
            // A new command level starts (or restarts) a burst from either state.
            target_nxt = cmd_in;
            bounce_nxt = cmd_in;
            if (BOUNCE_PAIRS == 0) begin
                state_nxt    = IDLE;
                busy_nxt     = 1'b0;
                done_nxt     = 1'b1;
                interval_nxt = '0;
                toggles_nxt  = '0;
            end else begin
                state_nxt    = BOUNCE;
                busy_nxt     = 1'b1;
                interval_nxt = interval_i;
                toggles_nxt  = TOGGLES_INIT;
            end
        end else if (state == BOUNCE) begin
            // Terminal count at 1 puts each toggle exactly I cycles after the last edge.
            if (interval_cnt == 32'd1) begin
                bounce_nxt  = ~bounce_out;
                toggles_nxt = toggles_left - 32'd1;
                if (toggles_left == 32'd1) begin
                    state_nxt    = IDLE;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b1;
                    interval_nxt = '0;
                end else begin
                    interval_nxt = interval_i;
                end
            end else begin
                interval_nxt = interval_cnt - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Directed bench for switch_bounce_emulator: a per-cycle vector table on a small deterministic
// instance, plus hand sequences for the zero-pair and jittered instances.
module tb_switch_bounce_emulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_a = 1'b1, byp_a = 1'b0, out_a, busy_a, done_a;
    logic cmd_z = 1'b1, byp_z = 1'b0, out_z, busy_z, done_z;
    logic cmd_j = 1'b1, byp_j = 1'b0, out_j, busy_j, done_j;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    switch_bounce_emulator #(.BOUNCE_INTERVAL(4), .BOUNCE_PAIRS(2), .JITTER_MASK(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .cmd_in(cmd_a), .bypass(byp_a),
        .bounce_out(out_a), .busy(busy_a), .done(done_a));

    switch_bounce_emulator #(.BOUNCE_INTERVAL(4), .BOUNCE_PAIRS(0), .JITTER_MASK(16'h0000)) dut_z (
        .clk(clk), .rst(rst), .cmd_in(cmd_z), .bypass(byp_z),
        .bounce_out(out_z), .busy(busy_z), .done(done_z));

    switch_bounce_emulator #(.BOUNCE_INTERVAL(4), .BOUNCE_PAIRS(7), .JITTER_MASK(16'h000F)) dut_j (
        .clk(clk), .rst(rst), .cmd_in(cmd_j), .bypass(byp_j),
        .bounce_out(out_j), .busy(busy_j), .done(done_j));

    typedef struct {
        logic r, b, c;      // rst, bypass, cmd_in applied before the edge
        logic o, bz, d;     // bounce_out, busy, done expected after the edge
    } vec_t;

    vec_t tbl[$];

    task automatic push(input int n, input logic r, input logic b, input logic c,
                        input logic o, input logic bz, input logic d);
        vec_t v;
        v.r = r; v.b = b; v.c = c; v.o = o; v.bz = bz; v.d = d;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        int cyc, last, toggles, dones;
        logic prev;
        bit fin;

        // reset and idle
        push(2, 1,0,1, 1,0,0);
        push(10, 0,0,1, 1,0,0);
        // full burst 1->0: edges at k, k+4, k+8, k+12, settle k+16
        push(1, 0,0,0, 0,1,0);
        push(3, 0,0,0, 0,1,0);
        push(4, 0,0,0, 1,1,0);
        push(4, 0,0,0, 0,1,0);
        push(4, 0,0,0, 1,1,0);
        push(1, 0,0,0, 0,0,1);
        push(2, 0,0,0, 0,0,0);
        // bypass square wave, period 6
        for (int p = 0; p < 5; p++) begin
            logic lv;
            lv = (p % 2 == 0);
            push(3, 0,1,lv, lv,0,0);
        end
        push(3, 0,0,1, 1,0,0);
        // burst 1->0 restarted at k+6 by cmd back to 1
        push(4, 0,0,0, 0,1,0);
        push(2, 0,0,0, 1,1,0);
        push(4, 0,0,1, 1,1,0);
        push(4, 0,0,1, 0,1,0);
        push(4, 0,0,1, 1,1,0);
        push(4, 0,0,1, 0,1,0);
        push(1, 0,0,1, 1,0,1);
        push(2, 0,0,1, 1,0,0);
        // reset during a glitch phase
        push(4, 0,0,0, 0,1,0);
        push(1, 0,0,0, 1,1,0);
        push(1, 1,0,0, 1,0,0);
        push(3, 0,0,1, 1,0,0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; byp_a = tbl[i].b; cmd_a = tbl[i].c;
            @(posedge clk); #1;
            chk($sformatf("row%0d bounce_out", i), int'(out_a), int'(tbl[i].o));
            chk($sformatf("row%0d busy", i), int'(busy_a), int'(tbl[i].bz));
            chk($sformatf("row%0d done", i), int'(done_a), int'(tbl[i].d));
        end

        // zero pairs: done on the same edge as the level change, no busy
        @(negedge clk); cmd_z = 1'b0;
        @(posedge clk); #1;
        chk("z fall out", int'(out_z), 0); chk("z fall done", int'(done_z), 1); chk("z fall busy", int'(busy_z), 0);
        @(posedge clk); #1;
        chk("z hold done", int'(done_z), 0); chk("z hold busy", int'(busy_z), 0); chk("z hold out", int'(out_z), 0);
        @(negedge clk); cmd_z = 1'b1;
        @(posedge clk); #1;
        chk("z rise out", int'(out_z), 1); chk("z rise done", int'(done_z), 1); chk("z rise busy", int'(busy_z), 0);
        @(posedge clk); #1;
        chk("z rise after done", int'(done_z), 0);

        // jittered burst: spacing in 4..19, 14 glitch toggles, single done
        @(negedge clk); cmd_j = 1'b0;
        @(posedge clk); #1;
        chk("j first edge out", int'(out_j), 0);
        chk("j first edge busy", int'(busy_j), 1);
        prev = out_j; last = 0; toggles = 0; dones = 0; fin = 1'b0;
        for (cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (out_j != prev) begin
                toggles++;
                chk("j spacing ge 4", int'(cyc - last >= 4), 1);
                chk("j spacing le 19", int'(cyc - last <= 19), 1);
                last = cyc;
                prev = out_j;
            end
            if (done_j) begin
                dones++;
                fin = 1'b1;
            end
        end
        chk("j finished within budget", int'(fin), 1);
        chk("j toggle count", toggles, 14);
        chk("j settled level", int'(out_j), 0);
        chk("j busy cleared", int'(busy_j), 0);
        @(posedge clk); #1;
        chk("j done single cycle", int'(done_j), 0);
        chk("j done count", dones, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
